mario_sprite_drawer: RTL

Per-pixel sprite stage that sits directly upstream of the big-Mario sprite ROM and downstream of the VGA timing counter. Each scan pixel is tested against Mario's on-screen bounding box, and the block generates the ROM `read_address` for pixels inside the box. The ROM's palette color is keyed against the transparency color and muxed over the background color. Mario's position, facing and flicker state are latched once per frame so the sprite never tears mid-frame.

---
 rtl/sprite_pkg.sv | 16 +
 rtl/sprite_addr_calc.sv | 54 +++++
 rtl/mario_sprite_drawer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the Mario sprite drawing stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_pkg;

    typedef logic [11:0] color_t;
    typedef logic [9:0]  coord_t;

    // Palette entry the ROM uses to mark see-through sprite pixels
    localparam color_t TRANSPARENT_KEY = 12'h808;

    // Big-Mario sprite dimensions
    localparam int SPRITE_W_DEF = 21;
    localparam int SPRITE_H_DEF = 41;

endpackage

// File: rtl/sprite_addr_calc.sv
// Combinational box test, optional horizontal mirror and sprite ROM address.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluates every cycle. Mirroring only with MARIO_MIRROR_EN.
module sprite_addr_calc
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = SPRITE_W_DEF,
    parameter int SPRITE_H = SPRITE_H_DEF
) (
    input  coord_t     draw_x,
    input  coord_t     draw_y,
    input  coord_t     sx,
    input  coord_t     sy,
    input  logic       sface,
    input  logic       blank,
    output logic       in_box,
    output logic [9:0] addr
);

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [9:0]  col_raw;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        hit;

`ifndef MARIO_MIRROR_EN
    // Facing is irrelevant when the sprite is always drawn unmirrored
    logic unused_sface;
    assign unused_sface = sface;
`endif

    // Box test on 11-bit ends so a box running off the screen edge clips instead of wrapping
    always_comb begin
        x_end   = {1'b0, sx} + 11'(SPRITE_W);
        y_end   = {1'b0, sy} + 11'(SPRITE_H);
        hit     = (draw_x >= sx) && ({1'b0, draw_x} < x_end) &&
                  (draw_y >= sy) && ({1'b0, draw_y} < y_end);
        col_raw = draw_x - sx;
        row     = draw_y - sy;
        col     = col_raw;
`ifdef MARIO_MIRROR_EN
        if (sface) begin
            col = 10'(SPRITE_W - 1) - col_raw;
        end
`endif
        in_box  = hit && !blank;
        addr    = '0;
        if (in_box) begin
            addr = row * 10'(SPRITE_W) + col;
        end
    end

endmodule

// File: rtl/mario_sprite_drawer.sv
// Per-pixel sprite overlay: frame-latched position, ROM addressing, colour key and background mux.
// Latency: 2 cycles pixel-in to pix_*; one pixel per cycle. Optional MARIO_MIRROR_EN mirrors left-facing sprite.
// Backpressure: none; both stages advance every cycle, invalid pixels flow through with pix_valid=0.
module mario_sprite_drawer
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = SPRITE_W_DEF,
    parameter int SPRITE_H = SPRITE_H_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pixel_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        vsync_start,
    input  logic [9:0]  mario_x,
    input  logic [9:0]  mario_y,
    input  logic        facing_left,
    input  logic        flicker,
    input  logic [11:0] bg_color,
    output logic [9:0]  read_address,
    input  logic [11:0] rom_color,
    output logic [11:0] pix_color,
    output logic        pix_valid,
    output logic        sprite_hit
);

    // Frame shadow state
    coord_t     sx_q, sx_d;
    coord_t     sy_q, sy_d;
    logic       sface_q, sface_d;
    logic       sflick_q, sflick_d;
    logic [2:0] fcnt_q, fcnt_d;

    // Stage A -> B
    logic [9:0] addr_q, addr_d;
    logic       in_box_q, in_box_d;
    color_t     bg_q, bg_d;
    logic       valid_q, valid_d;

    // Stage B outputs
    color_t     pix_color_q, pix_color_d;
    logic       pix_valid_q, pix_valid_d;
    logic       sprite_hit_q, sprite_hit_d;

    logic       calc_in_box;
    logic [9:0] calc_addr;
    logic       blank;
    logic       opaque;

    // Invincibility blink hides the sprite for the whole upper half of the 8-frame cycle
    assign blank = sflick_q && fcnt_q[2];

    sprite_addr_calc #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_addr_calc (
        .draw_x (DrawX),
        .draw_y (DrawY),
        .sx     (sx_q),
        .sy     (sy_q),
        .sface  (sface_q),
        .blank  (blank),
        .in_box (calc_in_box),
        .addr   (calc_addr)
    );

    // Shadow registers only move on vsync so a pixel coincident with the pulse still sees the old frame
    always_comb begin
        sx_d     = sx_q;
        sy_d     = sy_q;
        sface_d  = sface_q;
        sflick_d = sflick_q;
        fcnt_d   = fcnt_q;
        if (vsync_start) begin
            sx_d     = mario_x;
            sy_d     = mario_y;
            sface_d  = facing_left;
            sflick_d = flicker;
            fcnt_d   = fcnt_q + 3'd1;
        end
    end

    // Stage A: capture hit test, ROM address and the pixel's background
    always_comb begin
        addr_d   = calc_addr;
        in_box_d = calc_in_box;
        bg_d     = bg_color;
        valid_d  = pixel_valid;
    end

    // Stage B: key out transparent ROM colour; invalid pixels never report a hit
    always_comb begin
        opaque       = in_box_q && valid_q && (rom_color != TRANSPARENT_KEY);
        pix_color_d  = opaque ? rom_color : bg_q;
        sprite_hit_d = opaque;
        pix_valid_d  = valid_q;
    end

    // All state, synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sx_q         <= '0;
            sy_q         <= '0;
            sface_q      <= 1'b0;
            sflick_q     <= 1'b0;
            fcnt_q       <= '0;
            addr_q       <= '0;
            in_box_q     <= 1'b0;
            bg_q         <= '0;
            valid_q      <= 1'b0;
            pix_color_q  <= '0;
            pix_valid_q  <= 1'b0;
            sprite_hit_q <= 1'b0;
        end else begin
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            sface_q      <= sface_d;
            sflick_q     <= sflick_d;
            fcnt_q       <= fcnt_d;
            addr_q       <= addr_d;
            in_box_q     <= in_box_d;
            bg_q         <= bg_d;
            valid_q      <= valid_d;
            pix_color_q  <= pix_color_d;
            pix_valid_q  <= pix_valid_d;
            sprite_hit_q <= sprite_hit_d;
        end
    end

    assign read_address = addr_q;
    assign pix_color    = pix_color_q;
    assign pix_valid    = pix_valid_q;
    assign sprite_hit   = sprite_hit_q;

endmodule
